control_unit: RTL
=================

# control_unit

Multi-cycle controller that drives `datapath_mi` from the instruction side: it consumes the fetched instruction word `I` and the latched ALU flags `alu_status`, and produces the 22-bit `control_word` and immediate `K` each cycle. It sequences fetch, execute and two-cycle load, resolves conditional branches, halts on `HLT`, and counts retired instructions. It sits beside `datapath_mi` in the CPU top level.

## Interface
- `CW_W`, 22, control word width (field map below).
- `CNT_W`, 16, retired-instruction counter width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `I`  in  16  instruction register contents from datapath.
- `alu_status`  in  4  latched flags {V,C,N,Z}; Z = bit 0.
- `control_word`  out  22  {sl,il,pcl,mr,mw,b_sel,a_sel,en_alu,ci,FS[2:0],w,SB[2:0],SA[2:0],DA[2:0]}, MSB first.
- `K`  out  8  immediate to datapath.
- `halted`  out  1  high in HALT state.
- `retired`  out  CNT_W  instructions completed since reset.

## Operation
- Instruction format: op=I[15:12], s=I[11], DA=I[10:8], SA=I[7:5], SB=I[4:2]; immediate forms use R=I[10:8] and K=I[7:0].
- States: RESET, FETCH, EXEC, EXEC2, HALT.
- RESET: all-zero word, K=0; next FETCH.
- FETCH word: il=1, pcl=1, a_sel=1, en_alu=1, ci=1, FS=010, SB=111, others 0 (=22'h18E9C0). Next EXEC.
- EXEC words by op (unlisted fields 0; K=0 unless stated):
  - 0 AND/1 OR/2 ADD/3 SUB/4 SL/5 SR/6 XOR: en_alu=1, w=1, FS = 000/001/010/011/100/101/110, ci=1 only for SUB, sl=s, DA/SA/SB from I.
  - 7 MOVI: b_sel=1, en_alu=1, FS=001, w=1, SA=111, DA=R, K=I[7:0].
  - 8 LD: mr=1, DA=R, K=I[7:0], w=0; next EXEC2.
  - 9 ST: mw=1, en_alu=1, FS=001, SB=111, SA=R, K=I[7:0].
  - A B: pcl=1, b_sel=1, a_sel=1, en_alu=1, ci=1, FS=010, K=I[7:0].
  - B BR: pcl=1, en_alu=1, FS=001, SB=111, SA=R.
  - C BZ: B word if Z=1, else all-zero word.
  - D PCST: a_sel=1, en_alu=1, ci=1, FS=010, w=1, SB=111, DA=R.
  - E NOP: all-zero word.
  - F HLT: all-zero word; next HALT.
- EXEC2 (LD only): mr=1, w=1, DA=R, K=I[7:0]; next FETCH.
- HALT: all-zero word, K=0, absorbing until reset.
- `retired` increments by 1 on the edge leaving EXEC (non-LD, non-HLT), leaving EXEC2, and entering HALT; wraps modulo 2^CNT_W. BZ not taken still counts.

## Timing
- `control_word`, `K`, `halted` are combinational from state, `I`, `alu_status`; state and `retired` are registered.
- While `rst` low: state=RESET, `control_word`=0, `K`=0, `halted`=0, `retired`=0, regardless of clock.
- Reset asserted mid-instruction aborts immediately (async); no partial-retire count.
- First FETCH word appears one cycle after the first rising edge with `rst` high.
- Latency: 2 cycles per instruction (FETCH+EXEC); LD 3 cycles.
- BZ samples Z combinationally during EXEC; flags set by the immediately preceding instruction are visible because sl latches on that instruction's EXEC edge.
- `I` must be stable from the FETCH edge through EXEC/EXEC2; it is not re-sampled.

## Structure
- Shared package `cpu_pkg`: opcode constants, state enum, control-word field bit positions, FS codes, `CW_FETCH`/`CW_NOP` constants; also used by the datapath and benches.
- One sub-module is natural: `cw_decode` (pure combinational op+state+flags → word/K); `control_unit` holds the FSM and counter.

## Test plan
- Reset then I=16'h7702 (MOVI R7? no — R=7, K=2): cycle 1 word 0, cycle 2 word 22'h18E9C0, cycle 3 MOVI word with DA=111, K=8'h02; `retired`=1 after.
- I=16'h3A20 (SUB s=1, DA=2, SA=1, SB=0): EXEC word has sl=1, ci=1, FS=011, w=1, DA=010, SA=001, SB=000.
- I=16'h8303 (LD R3,#3): EXEC mr=1 w=0; EXEC2 mr=1 w=1 DA=011 K=3; next FETCH; `retired` +1 only after EXEC2.
- I=16'hC005 (BZ #5) with Z=1 → pcl=1, K=5; repeat with Z=0 → all-zero word; both increment `retired`.
- I=16'hF000 → HALT, `halted`=1, word 0 for 10 cycles, `retired` frozen; pulse `rst` low mid-cycle → immediate zeroing, restart at FETCH.
- Force `retired`=16'hFFFF via 65535 NOPs, one more NOP → wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, controller states, control-word field
// positions, ALU function-select codes and the fixed FETCH/NOP words.
package cpu_pkg;

    localparam int unsigned CW_BITS = 22;

    // Control-word bit positions (single bits) and field LSBs (3-bit fields)
    localparam int unsigned CW_SL     = 21;
    localparam int unsigned CW_IL     = 20;
    localparam int unsigned CW_PCL    = 19;
    localparam int unsigned CW_MR     = 18;
    localparam int unsigned CW_MW     = 17;
    localparam int unsigned CW_BSEL   = 16;
    localparam int unsigned CW_ASEL   = 15;
    localparam int unsigned CW_EN_ALU = 14;
    localparam int unsigned CW_CI     = 13;
    localparam int unsigned CW_FS     = 10;
    localparam int unsigned CW_WR     = 9;
    localparam int unsigned CW_SB     = 6;
    localparam int unsigned CW_SA     = 3;
    localparam int unsigned CW_DA     = 0;

    // Opcodes, I[15:12]
    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SL   = 4'h4;
    localparam logic [3:0] OP_SR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MOVI = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_B    = 4'hA;
    localparam logic [3:0] OP_BR   = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_PCST = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // ALU function-select codes
    localparam logic [2:0] FS_AND = 3'b000;
    localparam logic [2:0] FS_OR  = 3'b001;
    localparam logic [2:0] FS_ADD = 3'b010;
    localparam logic [2:0] FS_SUB = 3'b011;
    localparam logic [2:0] FS_SL  = 3'b100;
    localparam logic [2:0] FS_SR  = 3'b101;
    localparam logic [2:0] FS_XOR = 3'b110;

    localparam logic [2:0] REG_ZERO_SEL = 3'b111;

    localparam logic [CW_BITS-1:0] CW_FETCH = 22'h18E9C0;
    localparam logic [CW_BITS-1:0] CW_NOP   = '0;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_EXEC,
        S_EXEC2,
        S_HALT
    } state_t;

    function automatic logic [3:0] op_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/cw_decode.sv
// Combinational decoder: controller state + instruction + flags -> control word and immediate.
import cpu_pkg::*;

module cw_decode (
    input  state_t                state,
    input  logic [15:0]           I,
    input  logic [3:0]            alu_status,
    output logic [CW_BITS-1:0]    control_word,
    output logic [7:0]            K
);

    logic [3:0] op;
    logic [2:0] r_fld;
    logic [7:0] imm;
    logic       z_flag;
    logic       unused_flags;

    assign op           = op_of(I);
    assign r_fld        = I[10:8];
    assign imm          = I[7:0];
    assign z_flag       = alu_status[0];
    assign unused_flags = ^alu_status[3:1];

    // Build the word for the current state; every field defaults to zero
    always_comb begin
        control_word = CW_NOP;
        K            = '0;
        unique case (state)
            S_FETCH: control_word = CW_FETCH;
            S_EXEC: begin
                unique case (op)
                    OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SL, OP_SR, OP_XOR: begin
                        // Register ALU ops: FS code equals the low opcode bits
                        control_word[CW_SL]       = I[11];
                        control_word[CW_EN_ALU]   = 1'b1;
                        control_word[CW_CI]       = (op == OP_SUB);
                        control_word[CW_FS +: 3]  = op[2:0];
                        control_word[CW_WR]       = 1'b1;
                        control_word[CW_SB +: 3]  = I[4:2];
                        control_word[CW_SA +: 3]  = I[7:5];
                        control_word[CW_DA +: 3]  = I[10:8];
                    end
                    OP_MOVI: begin
                        control_word[CW_BSEL]     = 1'b1;
                        control_word[CW_EN_ALU]   = 1'b1;
                        control_word[CW_FS +: 3]  = FS_OR;
                        control_word[CW_WR]       = 1'b1;
                        control_word[CW_SA +: 3]  = REG_ZERO_SEL;
                        control_word[CW_DA +: 3]  = r_fld;
                        K                         = imm;
                    end
                    OP_LD: begin
                        control_word[CW_MR]       = 1'b1;
                        control_word[CW_DA +: 3]  = r_fld;
                        K                         = imm;
                    end
                    OP_ST: begin
                        control_word[CW_MW]       = 1'b1;
                        control_word[CW_EN_ALU]   = 1'b1;
                        control_word[CW_FS +: 3]  = FS_OR;
                        control_word[CW_SB +: 3]  = REG_ZERO_SEL;
                        control_word[CW_SA +: 3]  = r_fld;
                        K                         = imm;
                    end
                    OP_B, OP_BZ: begin
                        // BZ not taken leaves the all-zero word and K=0
                        if (op == OP_B || z_flag) begin
                            control_word[CW_PCL]      = 1'b1;
                            control_word[CW_BSEL]     = 1'b1;
                            control_word[CW_ASEL]     = 1'b1;
                            control_word[CW_EN_ALU]   = 1'b1;
                            control_word[CW_CI]       = 1'b1;
                            control_word[CW_FS +: 3]  = FS_ADD;
                            K                         = imm;
                        end
                    end
                    OP_BR: begin
                        control_word[CW_PCL]      = 1'b1;
                        control_word[CW_EN_ALU]   = 1'b1;
                        control_word[CW_FS +: 3]  = FS_OR;
                        control_word[CW_SB +: 3]  = REG_ZERO_SEL;
                        control_word[CW_SA +: 3]  = r_fld;
                    end
                    OP_PCST: begin
                        control_word[CW_ASEL]     = 1'b1;
                        control_word[CW_EN_ALU]   = 1'b1;
                        control_word[CW_CI]       = 1'b1;
                        control_word[CW_FS +: 3]  = FS_ADD;
                        control_word[CW_WR]       = 1'b1;
                        control_word[CW_SB +: 3]  = REG_ZERO_SEL;
                        control_word[CW_DA +: 3]  = r_fld;
                    end
                    default: ; // NOP, HLT: all-zero word
                endcase
            end
            S_EXEC2: begin
                control_word[CW_MR]       = 1'b1;
                control_word[CW_WR]       = 1'b1;
                control_word[CW_DA +: 3]  = r_fld;
                K                         = imm;
            end
            default: ; // RESET, HALT: all-zero word
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction controller: FETCH/EXEC(/EXEC2) sequencing, halt,
// and a wrapping retired-instruction counter.
import cpu_pkg::*;

module control_unit #(
    parameter int unsigned CW_W  = 22,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       I,
    input  logic [3:0]        alu_status,
    output logic [CW_W-1:0]   control_word,
    output logic [7:0]        K,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    state_t     state;
    logic [3:0] op;

    assign op     = op_of(I);
    assign halted = (state == S_HALT);

    cw_decode u_cw_decode (
        .state        (state),
        .I            (I),
        .alu_status   (alu_status),
        .control_word (control_word),
        .K            (K)
    );

    // Sequence the instruction phases and count retirements on the leaving edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_RESET;
            retired <= '0;
        end else begin
            unique case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH: state <= S_EXEC;
                S_EXEC: begin
                    if (op == OP_LD) begin
                        state <= S_EXEC2;
                    end else begin
                        retired <= retired + CNT_W'(1);
                        state   <= (op == OP_HLT) ? S_HALT : S_FETCH;
                    end
                end
                S_EXEC2: begin
                    retired <= retired + CNT_W'(1);
                    state   <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

endmodule
